hp_bank_writer: RTL and testbench
=================================

HP_BANK_WRITER -- requirements
Module: hp_bank_writer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clock PHY_CLK33_I, reset PHY_RSTn_I.
REQ-002 Port list, one per line (name, direction, width, meaning):
- PHY_CLK33_I  in  1  33 MHz clock
- PHY_RSTn_I  in  1  async active-low reset
- S_DATA_I  in  32  stream word
- S_BE_I  in  4  byte enables
- S_VALID_I  in  1  word valid
- S_LAST_I  in  1  last word of frame
- S_READY_O  out  1  writer accepts word
- HPRAM_ADD_O  out  12  HP-side bank word address
- HPRAM_DATA_O  out  32  HP-side write data
- HPRAM_WEN_O  out  4  HP-side byte write enables
- HP_MEM_IDLE_O  out  1  HP side between frames; bank may be swapped
- FRAME_CNT_O  out  16  completed frames, wraps
- LAST_LEN_O  out  13  words written in last frame (1..4096)
- OVF_O  out  1  sticky: a frame exceeded 4096 words
- OVF_CLR_I  in  1  one-cycle pulse, clears OVF_O
- CHECKSUM_O  out  32  sum of last frame (REQ-019 only)

Function
REQ-003 SHALL transfer a word when S_VALID_I and S_READY_O are both high at a rising edge.
REQ-004 All outputs SHALL be registered; an accepted word SHALL appear on HPRAM_* exactly 1 cycle after acceptance, for exactly 1 cycle.
REQ-005 HPRAM_WEN_O SHALL equal S_BE_I of the accepted word during its write cycle and 4'h0 otherwise.
REQ-006 States SHALL be IDLE, WRITE, DISCARD and DONE.
REQ-007 IDLE: HP_MEM_IDLE_O=1, S_READY_O=1; acceptance -> WRITE (or DONE if S_LAST_I), write address 0, HP_MEM_IDLE_O=0 from the next cycle.
REQ-008 WRITE: S_READY_O=1; each accepted word writes the current address plus 1; address increments modulo 4096.
REQ-009 WRITE: acceptance with S_LAST_I=1 -> DONE.
REQ-010 WRITE: acceptance of the 4097th word without S_LAST_I -> DISCARD; word not written (WEN 0); OVF_O set.
REQ-011 DISCARD: S_READY_O=1, no writes, acceptance with S_LAST_I -> DONE; LAST_LEN_O reports 4096.
REQ-012 DONE lasts exactly 1 cycle, S_READY_O=0: FRAME_CNT_O increments (FFFF->0000), LAST_LEN_O and CHECKSUM_O update, -> IDLE.
REQ-013 HP_MEM_IDLE_O SHALL be 1 only in IDLE, so a bank swap sampled on that signal never splits a frame.
REQ-014 Minimum inter-frame gap: 1 cycle (DONE); a word valid in DONE SHALL wait and be accepted in IDLE.
REQ-015 A word with S_VALID_I low SHALL change nothing; S_BE_I=0 SHALL still consume an address.
REQ-016 OVF_CLR_I and an overflow set in the same cycle: set wins.

Reset
REQ-017 On PHY_RSTn_I low, immediately: state IDLE, address 0, HPRAM_WEN_O=0, HPRAM_ADD_O=0, HPRAM_DATA_O=0, S_READY_O=0, HP_MEM_IDLE_O=1, FRAME_CNT_O=0, LAST_LEN_O=0, OVF_O=0, CHECKSUM_O=0.
REQ-018 Reset mid-frame SHALL abort the frame without counting it; S_READY_O returns to 1 on the first clock edge after release.

Configuration
REQ-019 Macro HP_WR_CHECKSUM_EN defined: CHECKSUM_O = mod-2^32 sum of all written words (S_BE_I ignored, discarded words excluded), accumulator cleared on entry to WRITE; undefined: CHECKSUM_O tied to 0, no accumulator.

Structure
REQ-020 Shared package SHALL hold the state enum, HP_BANK_DEPTH=4096, HP_ADDR_W=12 and LEN_W=13.
REQ-021 No sub-module is required; the checksum accumulator is inline.

Verification
REQ-022 A 4-word frame 0x11,0x22,0x33,0x44, BE=F, continuous valid SHALL give writes at addresses 0..3 on cycles 1..4 after first acceptance, then FRAME_CNT_O=1, LAST_LEN_O=4, CHECKSUM_O=0xAA.
REQ-023 A 1-word frame with S_LAST_I on the first word SHALL give IDLE->DONE->IDLE, LAST_LEN_O=1 and HP_MEM_IDLE_O low for exactly 2 cycles.
REQ-024 A 4100-word frame SHALL give the last write at address 4095, then OVF_O=1, LAST_LEN_O=4096, FRAME_CNT_O+1, and no WEN during DISCARD.
REQ-025 Back-to-back frames with valid held high SHALL give S_READY_O low for exactly the DONE cycle and no word lost or duplicated.
REQ-026 Reset asserted at word 100 SHALL make all outputs immediately equal the REQ-017 values; a following 2-word frame SHALL give FRAME_CNT_O=1 and LAST_LEN_O=2.
REQ-027 OVF_CLR_I pulsed in the same cycle as a new overflow SHALL leave OVF_O=1; a later lone pulse SHALL clear it.

Source files
------------

// File: rtl/hp_bank_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hp_bank_writer_pkg
// Purpose : Shared types and sizing for the HP-side bank writer.
// Revision: 1.0 - initial release
// ============================================================================
package hp_bank_writer_pkg;

    // Words in one HP bank and the matching address width
    localparam int HP_BANK_DEPTH = 4096;
    localparam int HP_ADDR_W     = 12;

    // Frame length counter is one bit wider so a full bank (4096) is representable
    localparam int LEN_W         = 13;

    // Writer states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WRITE   = 2'd1,
        ST_DISCARD = 2'd2,
        ST_DONE    = 2'd3
    } hp_state_e;

endpackage : hp_bank_writer_pkg
`default_nettype wire

// File: rtl/hp_bank_writer.sv
`default_nettype none
// ============================================================================
// Module  : hp_bank_writer
// Purpose : Writes a framed 32-bit stream into one HP-side RAM bank, one word
//           per address starting at 0. Words beyond the bank depth are dropped
//           and flagged with a sticky overflow. Frame statistics are published
//           once per frame during a one-cycle DONE gap.
// Options : HP_WR_CHECKSUM_EN - when defined, CHECKSUM_O carries the modulo
//           2^32 sum of the words written in the last frame; otherwise 0.
// Revision: 1.0 - initial release
// ============================================================================
module hp_bank_writer
    import hp_bank_writer_pkg::*;
(
    input  logic        PHY_CLK33_I,
    input  logic        PHY_RSTn_I,
    input  logic [31:0] S_DATA_I,
    input  logic [3:0]  S_BE_I,
    input  logic        S_VALID_I,
    input  logic        S_LAST_I,
    output logic        S_READY_O,
    output logic [11:0] HPRAM_ADD_O,
    output logic [31:0] HPRAM_DATA_O,
    output logic [3:0]  HPRAM_WEN_O,
    output logic        HP_MEM_IDLE_O,
    output logic [15:0] FRAME_CNT_O,
    output logic [12:0] LAST_LEN_O,
    output logic        OVF_O,
    input  logic        OVF_CLR_I,
    output logic [31:0] CHECKSUM_O
);

    localparam logic [LEN_W-1:0] c_FULL_LEN = LEN_W'(HP_BANK_DEPTH);
    localparam logic [LEN_W-1:0] c_LEN_ONE  = LEN_W'(1);

    hp_state_e              state_q, state_d;
    logic [LEN_W-1:0]       cnt_q, cnt_d;       // words written so far in this frame
    logic                   ready_q, ready_d;
    logic                   idle_q, idle_d;
    logic [HP_ADDR_W-1:0]   add_q, add_d;
    logic [31:0]            data_q, data_d;
    logic [3:0]             wen_q, wen_d;
    logic [15:0]            fcnt_q, fcnt_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic                   ovf_q, ovf_d;

    logic                   w_accept;
    logic                   w_ovf_set;

    assign w_accept = S_VALID_I & ready_q;

    // Next-state and next-output decode for the frame writer
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        add_d     = add_q;
        data_d    = data_q;
        wen_d     = 4'h0;
        fcnt_d    = fcnt_q;
        len_d     = len_q;
        w_ovf_set = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    add_d   = '0;
                    data_d  = S_DATA_I;
                    wen_d   = S_BE_I;
                    cnt_d   = c_LEN_ONE;
                    state_d = S_LAST_I ? ST_DONE : ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (w_accept) begin
                    if (cnt_q == c_FULL_LEN) begin
                        // Bank is full: this word and the rest of the frame are dropped
                        w_ovf_set = 1'b1;
                        state_d   = S_LAST_I ? ST_DONE : ST_DISCARD;
                    end else begin
                        add_d  = cnt_q[HP_ADDR_W-1:0];
                        data_d = S_DATA_I;
                        wen_d  = S_BE_I;
                        cnt_d  = cnt_q + c_LEN_ONE;
                        if (S_LAST_I) begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_DISCARD: begin
                if (w_accept && S_LAST_I) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                fcnt_d  = fcnt_q + 16'd1;
                len_d   = cnt_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new overflow takes priority over a simultaneous clear request
        if (w_ovf_set) begin
            ovf_d = 1'b1;
        end else if (OVF_CLR_I) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        ready_d = (state_d != ST_DONE);
        // Drop idle as soon as a frame starts, but raise it one cycle after
        // returning to IDLE so the frame statistics are already settled
        idle_d  = (state_d == ST_IDLE) && (state_q == ST_IDLE);
    end

    // Frame writer state and registered outputs
    always_ff @(posedge PHY_CLK33_I or negedge PHY_RSTn_I) begin
        if (!PHY_RSTn_I) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            idle_q  <= 1'b1;
            add_q   <= '0;
            data_q  <= '0;
            wen_q   <= 4'h0;
            fcnt_q  <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            idle_q  <= idle_d;
            add_q   <= add_d;
            data_q  <= data_d;
            wen_q   <= wen_d;
            fcnt_q  <= fcnt_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef HP_WR_CHECKSUM_EN
    logic [31:0] sum_q, sum_d;
    logic [31:0] csum_q, csum_d;

    // Running sum of written words; restarts with the first word of a frame
    always_comb begin
        sum_d  = sum_q;
        csum_d = csum_q;
        if (w_accept && (state_q == ST_IDLE)) begin
            sum_d = S_DATA_I;
        end else if (w_accept && (state_q == ST_WRITE) && (cnt_q != c_FULL_LEN)) begin
            sum_d = sum_q + S_DATA_I;
        end
        if (state_q == ST_DONE) begin
            csum_d = sum_q;
        end
    end

    // Checksum accumulator and published result
    always_ff @(posedge PHY_CLK33_I or negedge PHY_RSTn_I) begin
        if (!PHY_RSTn_I) begin
            sum_q  <= '0;
            csum_q <= '0;
        end else begin
            sum_q  <= sum_d;
            csum_q <= csum_d;
        end
    end

    assign CHECKSUM_O = csum_q;
`else
    assign CHECKSUM_O = 32'h0000_0000;
`endif

    assign S_READY_O     = ready_q;
    assign HP_MEM_IDLE_O = idle_q;
    assign HPRAM_ADD_O   = add_q;
    assign HPRAM_DATA_O  = data_q;
    assign HPRAM_WEN_O   = wen_q;
    assign FRAME_CNT_O   = fcnt_q;
    assign LAST_LEN_O    = len_q;
    assign OVF_O         = ovf_q;

endmodule : hp_bank_writer
`default_nettype wire

// File: tb/tb_hp_bank_writer.sv
`default_nettype none
// ============================================================================
// Module  : tb_hp_bank_writer
// Purpose : Self-checking bench for hp_bank_writer. A frame-level reference
//           model predicts RAM writes and frame statistics into queues; an
//           independent monitor compares them against the DUT outputs.
// Revision: 1.0 - initial release
// ============================================================================
module tb_hp_bank_writer;

`ifdef HP_WR_CHECKSUM_EN
    localparam bit c_CSUM_EN = 1'b1;
`else
    localparam bit c_CSUM_EN = 1'b0;
`endif
    localparam int c_DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] S_DATA_I = '0;
    logic [3:0]  S_BE_I = '0;
    logic        S_VALID_I = 1'b0;
    logic        S_LAST_I = 1'b0;
    logic        OVF_CLR_I = 1'b0;
    logic        S_READY_O;
    logic [11:0] HPRAM_ADD_O;
    logic [31:0] HPRAM_DATA_O;
    logic [3:0]  HPRAM_WEN_O;
    logic        HP_MEM_IDLE_O;
    logic [15:0] FRAME_CNT_O;
    logic [12:0] LAST_LEN_O;
    logic        OVF_O;
    logic [31:0] CHECKSUM_O;

    hp_bank_writer u_dut (
        .PHY_CLK33_I   (clk),
        .PHY_RSTn_I    (rst_n),
        .S_DATA_I      (S_DATA_I),
        .S_BE_I        (S_BE_I),
        .S_VALID_I     (S_VALID_I),
        .S_LAST_I      (S_LAST_I),
        .S_READY_O     (S_READY_O),
        .HPRAM_ADD_O   (HPRAM_ADD_O),
        .HPRAM_DATA_O  (HPRAM_DATA_O),
        .HPRAM_WEN_O   (HPRAM_WEN_O),
        .HP_MEM_IDLE_O (HP_MEM_IDLE_O),
        .FRAME_CNT_O   (FRAME_CNT_O),
        .LAST_LEN_O    (LAST_LEN_O),
        .OVF_O         (OVF_O),
        .OVF_CLR_I     (OVF_CLR_I),
        .CHECKSUM_O    (CHECKSUM_O)
    );

    always #15 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [11:0] add;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    typedef struct {
        int          cyc;
        logic [15:0] fcnt;
        logic [12:0] len;
        logic [31:0] csum;
    } fr_t;

    wr_t wq[$];
    fr_t fq[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state (frame level)
    bit          in_frame = 1'b0;
    int          fidx = 0;
    logic [31:0] fsum = '0;
    logic [15:0] m_fcnt = '0;
    logic        m_ovf = 1'b0;
    int          last_end = -10;
    int          rel_cyc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_reset();
        chk("rst_ready", S_READY_O, 0);
        chk("rst_idle", HP_MEM_IDLE_O, 1);
        chk("rst_add", HPRAM_ADD_O, 0);
        chk("rst_data", HPRAM_DATA_O, 0);
        chk("rst_wen", HPRAM_WEN_O, 0);
        chk("rst_fcnt", FRAME_CNT_O, 0);
        chk("rst_len", LAST_LEN_O, 0);
        chk("rst_ovf", OVF_O, 0);
        chk("rst_csum", CHECKSUM_O, 0);
    endtask

    // One stimulus cycle: drive at the falling edge, check handshake-level
    // outputs against the model, and predict what the next rising edge causes
    task automatic step(input bit v, input logic [31:0] d, input logic [3:0] be,
                        input bit last, input bit clr, output bit acc);
        wr_t w;
        fr_t f;
        bit  ovf_ev;
        @(negedge clk);
        S_VALID_I = v;
        S_DATA_I  = d;
        S_BE_I    = be;
        S_LAST_I  = last;
        OVF_CLR_I = clr;
        chk("ready", S_READY_O, (cyc != last_end) && (cyc > rel_cyc));
        chk("mem_idle", HP_MEM_IDLE_O, !in_frame && (cyc >= last_end + 2));
        chk("ovf", OVF_O, m_ovf);
        acc = v && S_READY_O;
        ovf_ev = acc && in_frame && (fidx == c_DEPTH);
        if (ovf_ev) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (acc) begin
            if (!in_frame) begin
                in_frame = 1'b1;
                fidx = 0;
                fsum = '0;
            end
            if (fidx < c_DEPTH) begin
                if (be != 4'h0) begin
                    w.cyc = cyc + 1; w.add = fidx[11:0]; w.data = d; w.be = be;
                    wq.push_back(w);
                end
                fsum = fsum + d;
            end
            fidx++;
            if (last) begin
                m_fcnt = m_fcnt + 16'd1;
                f.cyc  = cyc + 2;
                f.fcnt = m_fcnt;
                f.len  = (fidx > c_DEPTH) ? 13'd4096 : fidx[12:0];
                f.csum = c_CSUM_EN ? fsum : 32'h0;
                fq.push_back(f);
                in_frame = 1'b0;
                last_end = cyc + 1;
            end
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, $urandom, 4'($urandom), 1'b0, 1'b0, acc);
    endtask

    task automatic send_word(input logic [31:0] d, input logic [3:0] be, input bit last, input bit clr);
        bit acc;
        int tries;
        tries = 0;
        do begin
            step(1'b1, d, be, last, clr, acc);
            tries++;
        end while (!acc && tries < 8);
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    function automatic logic [3:0] rand_be();
        return ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
    endfunction

    task automatic send_frame(input int n, input bit gaps, input int clr_idx);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            send_word($urandom, rand_be(), i == n - 1, i == clr_idx);
        end
    endtask

    // Monitor: compare every RAM write and every frame completion
    int prev_fcnt = 0;
    initial begin
        wr_t w;
        fr_t f;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_fcnt = int'(FRAME_CNT_O);
            end else begin
                if (HPRAM_WEN_O != 4'h0) begin
                    if (wq.size() == 0) begin
                        chk("unexpected_write", {HPRAM_ADD_O, HPRAM_WEN_O}, 0);
                    end else begin
                        w = wq.pop_front();
                        chk("wr_cycle", cyc, w.cyc);
                        chk("wr_add", HPRAM_ADD_O, w.add);
                        chk("wr_data", HPRAM_DATA_O, w.data);
                        chk("wr_be", HPRAM_WEN_O, w.be);
                    end
                end
                if (wq.size() > 0 && wq[0].cyc < cyc) begin
                    w = wq.pop_front();
                    chk("missing_write_add", 12'hfff ^ w.add, w.add);
                end
                if (int'(FRAME_CNT_O) != prev_fcnt) begin
                    prev_fcnt = int'(FRAME_CNT_O);
                    if (fq.size() == 0) begin
                        chk("unexpected_frame", FRAME_CNT_O, 16'hxxxx);
                    end else begin
                        f = fq.pop_front();
                        chk("fr_cycle", cyc, f.cyc);
                        chk("fr_count", FRAME_CNT_O, f.fcnt);
                        chk("fr_len", LAST_LEN_O, f.len);
                        chk("fr_csum", CHECKSUM_O, f.csum);
                    end
                end
                if (fq.size() > 0 && fq[0].cyc < cyc) begin
                    f = fq.pop_front();
                    chk("missing_frame_count", FRAME_CNT_O, f.fcnt);
                end
            end
        end
    end

    initial begin
        #(30 * 60000);
        $display("FAIL watchdog: got still running want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-on reset
        #1 rst_n = 1'b0;
        #1 chk_reset();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        rel_cyc = cyc;

        // Four-word reference frame
        send_word(32'h11, 4'hF, 1'b0, 1'b0);
        send_word(32'h22, 4'hF, 1'b0, 1'b0);
        send_word(32'h33, 4'hF, 1'b0, 1'b0);
        send_word(32'h44, 4'hF, 1'b1, 1'b0);
        idle(3);
        chk("frame1_len", LAST_LEN_O, 4);
        chk("frame1_csum", CHECKSUM_O, c_CSUM_EN ? 32'hAA : 32'h0);

        // Single-word frame
        send_word($urandom, 4'hF, 1'b1, 1'b0);
        idle(4);
        chk("single_len", LAST_LEN_O, 1);

        // Back-to-back frames with valid held high
        send_frame(3, 1'b0, -1);
        send_frame(1, 1'b0, -1);
        send_frame(5, 1'b0, -1);
        idle(3);

        // Randomised frames with random gaps
        for (int k = 0; k < 30; k++) begin
            send_frame($urandom_range(1, 24), 1'b1, -1);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        idle(3);

        // Overflow frame; clear pulsed together with the overflowing word
        send_frame(4100, 1'b0, 4096);
        idle(4);
        chk("ovf_held", OVF_O, 1);
        chk("ovf_len", LAST_LEN_O, 4096);
        begin
            bit acc;
            step(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, acc);
        end
        idle(2);
        chk("ovf_cleared", OVF_O, 0);

        // Reset in the middle of a frame
        for (int i = 0; i < 100; i++) send_word($urandom, rand_be(), 1'b0, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_reset();
        wq.delete();
        fq.delete();
        in_frame = 1'b0;
        m_fcnt = '0;
        m_ovf = 1'b0;
        last_end = -10;
        S_VALID_I = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        rel_cyc = cyc;
        send_frame(2, 1'b0, -1);
        idle(4);
        chk("post_rst_fcnt", FRAME_CNT_O, 1);
        chk("post_rst_len", LAST_LEN_O, 2);

        chk("writes_drained", wq.size(), 0);
        chk("frames_drained", fq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_hp_bank_writer
`default_nettype wire
